// File: rtl/dec_entry_pkg.sv
// Purpose: shared types and constants for the decimal-entry block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dec_entry_pkg;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    CONV  = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0]  NDIG          = 3'd4;      // max digits held in the entry
  localparam int          ACC_W         = 14;        // wide enough for 9999
  localparam logic [ACC_W-1:0] MAX_VAL  = 14'd8191;  // 13-bit saturation ceiling
  localparam logic [3:0]  DIG_BACKSPACE = 4'hB;

endpackage

// File: rtl/dec_mac10.sv
// Purpose: one decimal accumulate step, acc_out = acc_in*10 + digit.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
// Ports: acc_in (ACC_W) running value, digit (4) BCD nibble, acc_out (ACC_W) result.
module dec_mac10
  import dec_entry_pkg::*;
(
  input  logic [ACC_W-1:0] acc_in,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_out
);

  // x*10 as x*8 + x*2 keeps this a pair of adders with no multiplier.
  assign acc_out = (acc_in << 3) + (acc_in << 1) + {{(ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/dec_entry13.sv
// Purpose: calculator-style 4-digit BCD entry, converted to a saturated 13-bit value on commit.
// Latency: fixed 5 cycles from sampled i_enter to the o_val_valid pulse.
// Backpressure: none; strobes arriving while o_busy is high are dropped.
// Ports: i_clk/i_rst (async, active-high); i_digit_valid+i_digit key strobe; i_clear, i_enter
//        strobes; o_bcd/o_ndigits live entry; o_busy; o_val_valid+o_val result; o_err sticky.
// Build option: define DEC_ENTRY_BACKSPACE_EN to make key code 4'hB delete the last digit.
module dec_entry13
  import dec_entry_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_digit_valid,
  input  logic [3:0]  i_digit,
  input  logic        i_clear,
  input  logic        i_enter,
  output logic [15:0] o_bcd,
  output logic [2:0]  o_ndigits,
  output logic        o_busy,
  output logic        o_val_valid,
  output logic [12:0] o_val,
  output logic        o_err
);

  state_t             state_q, state_d;
  logic [15:0]        shadow_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_nxt;
  logic [1:0]         cnt_q;
  logic [3:0]         cur_dig;
  logic               over_max;

  // Most significant nibble first.
  always_comb begin
    cur_dig = 4'h0;
    case (cnt_q)
      2'd0: cur_dig = shadow_q[15:12];
      2'd1: cur_dig = shadow_q[11:8];
      2'd2: cur_dig = shadow_q[7:4];
      default: cur_dig = shadow_q[3:0];
    endcase
  end

  dec_mac10 u_mac (
    .acc_in  (acc_q),
    .digit   (cur_dig),
    .acc_out (acc_nxt)
  );

  assign over_max = (acc_nxt > MAX_VAL);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ENTRY;
    else       state_q <= state_d;
  end

  // Next-state logic; i_clear outranks i_enter in ENTRY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENTRY:   if (!i_clear && i_enter) state_d = CONV;
      CONV:    if (cnt_q == 2'd3)       state_d = DONE;
      DONE:    state_d = ENTRY;
      default: state_d = ENTRY;
    endcase
  end

  // Output decode straight from the state register, so no input-to-output path.
  always_comb begin
    o_busy      = (state_q != ENTRY);
    o_val_valid = (state_q == DONE);
  end

  // Entry, conversion and result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bcd     <= 16'h0000;
      o_ndigits <= 3'd0;
      o_err     <= 1'b0;
      o_val     <= 13'd0;
      shadow_q  <= 16'h0000;
      acc_q     <= '0;
      cnt_q     <= 2'd0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (i_clear) begin
            o_bcd     <= 16'h0000;
            o_ndigits <= 3'd0;
            o_err     <= 1'b0;
          end else if (i_enter) begin
            shadow_q <= o_bcd;
            acc_q    <= '0;
            cnt_q    <= 2'd0;
          end else if (i_digit_valid) begin
            if (i_digit <= 4'd9) begin
              if (o_ndigits < NDIG) begin
                o_bcd     <= {o_bcd[11:0], i_digit};
                o_ndigits <= o_ndigits + 3'd1;
              end else begin
                o_err <= 1'b1;  // entry full: digit dropped
              end
            end
`ifdef DEC_ENTRY_BACKSPACE_EN
            else if (i_digit == DIG_BACKSPACE && o_ndigits != 3'd0) begin
              o_bcd     <= {4'h0, o_bcd[15:4]};
              o_ndigits <= o_ndigits - 3'd1;
            end
`endif
          end
        end
        CONV: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 2'd1;
          // Final step: load the result so it is visible alongside o_val_valid in DONE.
          if (cnt_q == 2'd3) begin
            o_val     <= over_max ? MAX_VAL[12:0] : acc_nxt[12:0];
            o_bcd     <= 16'h0000;
            o_ndigits <= 3'd0;
            if (over_max) o_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dec_entry13.md
# dec_entry13

Sequential decimal-entry block: gathers up to four key-pressed decimal digits calculator-style, then converts the BCD entry into a 13-bit binary value (0..8191) on an explicit commit. It is the input-side counterpart of the four-digit 7-segment display path: keypad/switch logic feeds it, and it produces the binary operand consumed by the lab datapath. Its live BCD entry can drive the display decoder directly.

## Interface
- NDIG, 4, maximum number of entered digits
- MAX_VAL, 8191, saturation ceiling for the converted value

- i_clk  in  1  single system clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_digit_valid  in  1  one-cycle strobe; i_digit is valid this cycle
- i_digit  in  4  key code; 0..9 are digits
- i_clear  in  1  one-cycle strobe; discard the current entry
- i_enter  in  1  one-cycle strobe; commit the entry for conversion
- o_bcd  out  16  current entry, 4 BCD nibbles, [3:0] = ones
- o_ndigits  out  3  number of digits entered (0..4)
- o_busy  out  1  high while in CONV or DONE
- o_val_valid  out  1  one-cycle pulse; o_val is valid
- o_val  out  13  converted binary value, held until the next commit
- o_err  out  1  sticky; overflow or digit dropped; cleared by i_clear or i_rst

## Operation
- FSM states: ENTRY, CONV, DONE. Reset state is ENTRY.
- ENTRY state, priority order is i_clear > i_enter > i_digit_valid:
  - i_clear: o_bcd <= 0, o_ndigits <= 0, o_err <= 0.
  - i_enter: latch o_bcd into the conversion shadow register, acc <= 0, cnt <= 0, go to CONV. Any digit strobe in the same cycle is dropped.
  - i_digit_valid with i_digit <= 9 and o_ndigits < 4: o_bcd <= {o_bcd[11:0], i_digit}, o_ndigits++.
  - i_digit_valid with a valid digit and o_ndigits == 4: entry unchanged; o_err <= 1.
  - i_digit_valid with codes 10..15: ignored. See Configuration for 4'hB.
- CONV state: one digit per cycle, most significant first: acc <= acc*10 + shadow nibble[3-cnt], cnt++. acc is 14 bits (max 9999). After the 4th step, go to DONE.
- DONE state:
  - If acc > MAX_VAL: o_val <= MAX_VAL and o_err <= 1. Otherwise o_val <= acc[12:0].
  - o_val_valid = 1 for exactly this cycle.
  - Entry is cleared (o_bcd = 0, o_ndigits = 0). Next state is ENTRY.
- In CONV and DONE, all of i_digit_valid, i_clear and i_enter are ignored.
- Committing an empty entry converts to 0 and is a legal result.
- o_err is not cleared by a commit; only i_clear or i_rst clear it.

## Timing
- Reset values: o_bcd = 0, o_ndigits = 0, o_busy = 0, o_val_valid = 0, o_val = 0, o_err = 0. FSM = ENTRY.
- Digit strobe sampled at edge E: o_bcd and o_ndigits update after E.
- i_enter sampled at the end of cycle N:
  - o_busy is high in cycles N+1..N+5.
  - CONV steps occur in cycles N+1..N+4.
  - o_val_valid and the new o_val appear in cycle N+5.
  - ENTRY is active again in cycle N+6.
  - Fixed latency: 5 cycles.
- Back-to-back commits: the earliest next accepted i_enter is in cycle N+6.
- Asserting i_rst mid-CONV aborts immediately: all outputs take reset values and no o_val_valid pulse is issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DEC_ENTRY_BACKSPACE_EN defined:
  - In ENTRY, i_digit_valid with i_digit == 4'hB and o_ndigits > 0 does o_bcd <= {4'h0, o_bcd[15:4]}, o_ndigits--.
  - With o_ndigits == 0, the same strobe is a no-op.
  - Priority: below i_clear and i_enter.
- DEC_ENTRY_BACKSPACE_EN undefined: 4'hB is ignored like the other non-digit codes.

## Structure
- Package dec_entry_pkg holds:
  - state enum {ENTRY, CONV, DONE}
  - localparams NDIG = 4, MAX_VAL = 8191, ACC_W = 14, DIG_BACKSPACE = 4'hB
- Sub-module dec_mac10: combinational single step, acc_out = (acc<<3) + (acc<<1) + digit, widths ACC_W in and out. Instantiated once in dec_entry13.

## Test plan
- Enter digits 1,2,3,4 then i_enter → o_bcd = 16'h1234, o_ndigits = 4; o_val_valid exactly 5 cycles after enter, o_val = 1234, o_err = 0.
- Enter 9,9,9,9 then i_enter → o_val = 8191, o_err = 1. Then i_clear → o_err = 0.
- Enter 5,6,7,8,9 → 5th digit dropped, o_bcd = 16'h5678, o_err = 1. Commit → o_val = 5678.
- i_enter with no digits → o_val_valid with o_val = 0. Digit strobes during o_busy → entry stays 0.
- Simultaneous i_clear + i_digit_valid (7) → entry empty. Simultaneous i_enter + digit → digit dropped. Codes 4'hA and 4'hF → ignored.
- i_rst asserted in the 2nd CONV cycle after entering 4,2 → all outputs take reset values, no o_val_valid pulse. With DEC_ENTRY_BACKSPACE_EN: enter 4,2 then 4'hB → o_bcd = 16'h0004, o_ndigits = 1.
